// File: rtl/uart_frame_tx.sv
// Serialises one game-state frame (sync, seq, payload, XOR checksum) into the buffered UART.
// First write two cycles after send; each byte waits in SEND while tx_full is high.
module uart_frame_tx #(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       send,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  input  logic                       tx_full,
  output logic                       wr_uart,
  output logic [7:0]                 w_data,
  output logic                       busy,
  output logic                       done_tick
);

  localparam int TOTAL = PAYLOAD_BYTES + 3;
  localparam int IW    = 5;
  localparam int PW    = 8 * PAYLOAD_BYTES;

  localparam logic [IW-1:0] IDX_TOTAL = IW'(TOTAL);
  localparam logic [IW-1:0] IDX_CHK   = IW'(TOTAL - 1);
  localparam logic [IW-1:0] IDX_LASTP = IW'(TOTAL - 2);
  localparam logic [IW-1:0] IDX_FIRSTP = IW'(2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    seq_q, seq_d;
  logic [PW-1:0] hold_q, hold_d;
  logic          wr_q, wr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cur_byte;

  // Payload is consumed from the top of the hold register, so the current payload byte is always its MSB.
  always_comb begin
    cur_byte = hold_q[PW-1 -: 8];
    if (idx_q == '0) begin
      cur_byte = SYNC_BYTE;
    end else if (idx_q == IW'(1)) begin
      cur_byte = seq_q;
    end else if (idx_q == IDX_CHK) begin
      cur_byte = chk_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    seq_d   = seq_q;
    hold_d  = hold_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (send) begin
          hold_d  = payload;
          idx_d   = '0;
          chk_d   = 8'h00;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_full) begin
          wr_d    = 1'b1;
          wdata_d = cur_byte;
          if ((idx_q != '0) && (idx_q <= IDX_LASTP)) begin
            chk_d = chk_q ^ cur_byte;
          end
          if ((idx_q >= IDX_FIRSTP) && (idx_q <= IDX_LASTP)) begin
            hold_d = hold_q << 8;
          end
          idx_d   = idx_q + 1'b1;
          state_d = S_GAP;
        end
      end
      // Spacer cycle: the UART's tx_full only reflects our write one cycle later.
      S_GAP: begin
        if (idx_q == IDX_TOTAL) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        seq_d   = seq_q + 8'h01;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      chk_q   <= 8'h00;
      seq_q   <= 8'h00;
      hold_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      seq_q   <= seq_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_uart   = wr_q;
  assign w_data    = wdata_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: expected bytes queued at stimulus time, popped by a monitor on wr_uart.
module tb_uart_frame_tx;

  localparam int PB    = 4;
  localparam int TOTAL = PB + 3;

  logic          clk;
  logic          reset;
  logic          send;
  logic [8*PB-1:0] payload;
  logic          tx_full;
  logic          wr_uart;
  logic [7:0]    w_data;
  logic          busy;
  logic          done_tick;

  uart_frame_tx #(.PAYLOAD_BYTES(PB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .send(send), .payload(payload), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .done_tick(done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int frames_exp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tb_seq = 8'h00;
  logic prev_wr  = 1'b0;
  logic last_txf = 1'b0;
  logic bp_en    = 1'b0;
  int   bp_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_bytes(input logic [8*TOTAL-1:0] v);
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(v[8*TOTAL-1-8*i -: 8]);
  endtask

  task automatic push_model(input logic [8*PB-1:0] pl);
    logic [7:0] c;
    logic [7:0] b;
    c = tb_seq;
    exp_q.push_back(8'hA5);
    exp_q.push_back(tb_seq);
    for (int k = 0; k < PB; k++) begin
      b = pl[8*PB-1-8*k -: 8];
      c = c ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(c);
    tb_seq = tb_seq + 8'h01;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_tick && n < maxc);
    check("done_within_budget", {31'd0, done_tick}, 32'd1);
  endtask

  task automatic run_frame(input logic [8*PB-1:0] pl, input logic [8*TOTAL-1:0] bytes, input int maxc);
    payload = pl;
    push_bytes(bytes);
    frames_exp++;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_done(maxc);
  endtask

  initial forever @(posedge clk) begin
    cyc++;
    last_txf = tx_full;
  end

  // Monitor: pops the scoreboard on every strobe and checks strobe spacing and frame completion.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (wr_uart) begin
        check("strobe_spacing", {31'd0, prev_wr}, 32'd0);
        check("tx_full_low_at_decision", {31'd0, last_txf}, 32'd0);
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("w_data", {24'd0, w_data}, {24'd0, exp_q.pop_front()});
      end
      if (done_tick) begin
        check("frame_complete_at_done", exp_q.size(), 32'd0);
        check("busy_at_done", {31'd0, busy}, 32'd1);
        done_cnt++;
      end
    end
    prev_wr = wr_uart;
  end

  // Back-pressure: hold tx_full high for 20 cycles after each write.
  initial forever begin
    @(negedge clk);
    if (bp_en) begin
      if (wr_uart) begin
        tx_full = 1'b1;
        bp_cnt  = 20;
      end else if (bp_cnt > 0) begin
        bp_cnt--;
        if (bp_cnt == 0) tx_full = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    int c1, cw, cd, prev_cd, k, n;
    logic [7:0] ib;
    reset = 1'b1; send = 1'b0; payload = '0; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_uart", {31'd0, wr_uart}, 32'd0);
    check("rst_w_data", {24'd0, w_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done_tick}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: minimum-latency frame
    payload = 32'h11223344;
    push_bytes(56'hA5_00_11_22_33_44_44);
    frames_exp++;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    c1 = cyc;
    check("busy_cycle1", {31'd0, busy}, 32'd1);
    check("no_wr_cycle1", {31'd0, wr_uart}, 32'd0);
    n = 0;
    while (!wr_uart && n < 20) begin @(negedge clk); n++; end
    cw = cyc;
    check("first_wr_latency", cw - c1, 32'd1);
    wait_done(40);
    cd = cyc;
    check("done_latency", cd - c1, 2 * TOTAL);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done_tick}, 32'd0);
    repeat (2) @(negedge clk);

    // 2: second frame, seq advances
    run_frame(32'h11223344, 56'hA5_01_11_22_33_44_45, 40);
    repeat (3) @(negedge clk);

    // 3: back-pressure
    bp_en = 1'b1;
    run_frame(32'h11223344, 56'hA5_02_11_22_33_44_46, 400);
    repeat (25) @(negedge clk);
    bp_en = 1'b0;
    tx_full = 1'b0;
    @(negedge clk);

    // 4: send while busy and payload changed mid-frame
    payload = 32'hDEADBEEF;
    push_bytes(56'hA5_03_DE_AD_BE_EF_21);
    frames_exp++;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (2) @(negedge clk);
    payload = 32'h0BADF00D;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (3) @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_done(40);
    repeat (20) @(negedge clk);
    check("no_extra_frame_busy", {31'd0, busy}, 32'd0);
    check("no_extra_frame_bytes", exp_q.size(), 32'd0);

    // 5: reset after third byte
    payload = 32'hCAFEF00D;
    push_bytes(56'hA5_04_CA_FE_F0_0D_CD);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    k = 0; n = 0;
    while (k < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (wr_uart) k++;
    end
    check("three_bytes_before_reset", k, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    tb_seq = 8'h00;
    @(negedge clk);
    check("reset_mid_wr", {31'd0, wr_uart}, 32'd0);
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check("reset_mid_w_data", {24'd0, w_data}, 32'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("abandoned_frame_idle", {31'd0, busy}, 32'd0);

    // 6: 257 back-to-back frames with send held high, seq wraps
    prev_cd = 0;
    ib = 8'h00;
    payload = {ib, ~ib, ib ^ 8'h5A, 8'h3C};
    push_model(payload);
    frames_exp++;
    send = 1'b1;
    for (int i = 0; i < 257; i++) begin
      wait_done(40);
      cd = cyc;
      if (i > 0) check("b2b_done_interval", cd - prev_cd, 2 * TOTAL + 2);
      prev_cd = cd;
      if (i < 256) begin
        ib = 8'(i + 1);
        payload = {ib, ~ib, ib ^ 8'h5A, 8'h3C};
        push_model(payload);
        frames_exp++;
      end else begin
        send = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("done_count", done_cnt, frames_exp);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
